// File: rtl/keypad_hex_entry.sv
// ---------------------------------------------------------------------------
// keypad_hex_entry
//
// Scans a 4x4 hex matrix keypad, debounces presses and releases over whole
// scan frames, and shifts each accepted digit into a 32-bit entry register
// that drives the seven-segment display bus (newest digit in [3:0]).
//
// Parameters:
//   SCAN_DIV  clk cycles each row stays strobed (>= 2)
//   DEBOUNCE  consecutive identical frame results needed to accept (>= 1)
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, active-low
//   row[3:0]    row strobes, active-low, one bit low at a time
//   col[3:0]    column sense, active-low (external pull-ups)
//   clear       synchronous clear of entry_data (wins over a same-edge accept)
//   key_code    hex code of the last accepted key, held between events
//   key_valid   one-cycle pulse on each accepted press
//   entry_data  accumulated hex digits, newest in [3:0]
// ---------------------------------------------------------------------------
module keypad_hex_entry #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic        clear,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [31:0] entry_data
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_q, row_d;

    // Frame accumulator: number of low intersections seen so far this
    // frame (saturating at 2, which already means MULTI) and the code of
    // the first one.
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]    acc_code_q, acc_code_d;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic [31:0]   entry_q, entry_d;

    logic          sample;
    logic          frame_done;
    logic [2:0]    cur_cnt;
    logic [1:0]    cur_c;
    logic [2:0]    sum_cnt;
    logic [1:0]    frame_cnt;
    logic [3:0]    frame_code;
    logic          frame_none;
    logic          frame_key;
    logic [CW-1:0] cnt_inc;
    logic          cnt_done;
    logic          accept;

    assign row        = row_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign entry_data = entry_q;

    // Row scanning: divider, row index and the rotating strobe pattern.
    // The column sample and the row rotation happen on the same edge.
    always_comb begin
        sample    = (div_q == DW'(SCAN_DIV - 1));
        div_d     = sample ? '0 : div_q + 1'b1;
        row_idx_d = sample ? row_idx_q + 2'd1 : row_idx_q;
        row_d     = sample ? {row_q[2:0], row_q[3]} : row_q;
    end

    // Classify the sampled columns of the current row and merge them with
    // what earlier rows of this frame contributed.
    always_comb begin
        cur_cnt = '0;
        cur_c   = '0;
        for (int c = 3; c >= 0; c--) begin
            if (!col[c]) begin
                cur_cnt = cur_cnt + 3'd1;
                cur_c   = 2'(c);
            end
        end
        sum_cnt    = {1'b0, acc_cnt_q} + cur_cnt;
        frame_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        frame_code = (acc_cnt_q != 2'd0) ? acc_code_q : {row_idx_q, cur_c};
        frame_done = sample && (row_idx_q == 2'd3);
        frame_none = frame_done && (frame_cnt == 2'd0);
        frame_key  = frame_done && (frame_cnt == 2'd1);

        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (frame_done) begin
            acc_cnt_d  = '0;
            acc_code_d = '0;
        end else if (sample) begin
            acc_cnt_d  = frame_cnt;
            acc_code_d = frame_code;
        end
    end

    // Debounce FSM. MULTI frames (frame_done with neither NONE nor KEY)
    // fall through every branch and leave state and counter untouched.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        cnt_done = (cnt_inc == CW'(DEBOUNCE));

        case (state_q)
            IDLE: begin
                if (frame_key) begin
                    cand_d = frame_code;
                    cnt_d  = CW'(1);
                    if (DEBOUNCE == 1) begin
                        accept  = 1'b1;
                        state_d = HELD;
                    end else begin
                        state_d = PRESS_DB;
                    end
                end
            end
            PRESS_DB: begin
                if (frame_none) begin
                    state_d = IDLE;
                end else if (frame_key) begin
                    if (frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        cand_d = frame_code;
                        cnt_d  = CW'(1);
                    end
                end
            end
            HELD: begin
                if (frame_none) begin
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE == 1) ? IDLE : RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                if (frame_key) begin
                    state_d = HELD;
                end else if (frame_none) begin
                    cnt_d = cnt_inc;
                    if (cnt_done) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers: the accepted code, the one-cycle event and the
    // shifting entry register, where clear overrides a same-edge accept.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        entry_d     = entry_q;
        if (accept) begin
            key_code_d  = cand_d;
            key_valid_d = 1'b1;
            entry_d     = {entry_q[27:0], cand_d};
        end
        if (clear) begin
            entry_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q       <= '0;
            row_idx_q   <= '0;
            row_q       <= 4'b1110;
            acc_cnt_q   <= '0;
            acc_code_q  <= '0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            entry_q     <= '0;
        end else begin
            div_q       <= div_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            entry_q     <= entry_d;
        end
    end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// ---------------------------------------------------------------------------
// tb_keypad_hex_entry
//
// Bench for keypad_hex_entry with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames).
// A keypad model turns the set of pressed keys into active-low column
// levels for whichever row is strobed. Each press that should be accepted
// pushes its expected key_code/entry_data into a queue; a monitor pops and
// compares on every key_valid pulse, and flags pulses nobody expected.
// Stimulus changes are kept aligned to frame boundaries after reset.
// ---------------------------------------------------------------------------
module tb_keypad_hex_entry;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [31:0] entry_data;

    logic [15:0] pressed;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_entry;
    int          vectors;
    int          miscompares;

    keypad_hex_entry #(
        .SCAN_DIV(4),
        .DEBOUNCE(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .clear     (clear),
        .key_code  (key_code),
        .key_valid (key_valid),
        .entry_data(entry_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: key 4*r+c pulls col[c] low while row[r] is strobed.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r+c] && !row[r]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input int cycles);
        pressed = keys;
        waitCycles(cycles);
    endtask

    task automatic expectKey(input logic [3:0] code, input logic clr);
        exp_t e;
        exp_entry = clr ? 32'h0 : {exp_entry[27:0], code};
        e.code = code;
        e.data = exp_entry;
        sb.push_back(e);
    endtask

    task automatic checkResetValues();
        checkOutput("reset_row", {28'h0, row}, 32'h0000000E);
        checkOutput("reset_key_code", {28'h0, key_code}, 32'h0);
        checkOutput("reset_key_valid", {31'h0, key_valid}, 32'h0);
        checkOutput("reset_entry_data", entry_data, 32'h0);
    endtask

    // Hold rst_n low for two edges, check reset values, then release on a
    // falling edge; the next rising edge starts a fresh frame.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        waitCycles(2);
        checkResetValues();
        exp_entry = 32'h0;
        rst_n = 1'b1;
    endtask

    // Press one key (aligned), hold, release.
    task automatic typeKey(input logic [3:0] code, input int hold, input int rel);
        expectKey(code, 1'b0);
        applyStimulus(16'h1 << code, hold);
        applyStimulus(16'h0, rel);
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && key_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_key_valid", {31'h0, key_valid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("key_code", {28'h0, key_code}, {28'h0, e.code});
                    checkOutput("entry_data", entry_data, e.data);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_entry   = 32'h0;
        pressed     = 16'h0;
        clear       = 1'b0;
        rst_n       = 1'b0;

        fork
            monitorLoop();
        join_none

        // 1: idle scanning, row pattern every 4 cycles
        doReset();
        for (int k = 0; k < 64; k++) begin
            if (k % 4 == 0) begin
                checkOutput("row_rotation", {28'h0, row},
                            {28'h0, ~(4'b0001 << ((k / 4) % 4))});
            end
            waitCycles(1);
        end
        checkOutput("idle_entry_data", entry_data, 32'h0);

        // 2: key 6 held 5 frames; pulse lands after the 2nd pressed frame
        expectKey(4'h6, 1'b0);
        applyStimulus(16'h1 << 6, 31);
        checkOutput("key6_no_early_pulse", {31'h0, key_valid}, 32'h0);
        waitCycles(1);
        checkOutput("key6_pulse_timing", {31'h0, key_valid}, 32'h1);
        waitCycles(48);
        applyStimulus(16'h0, 64);
        checkOutput("key6_entry_data", entry_data, 32'h00000006);

        // 3: keys 1..9, the ninth digit pushes the oldest out
        for (int k = 1; k <= 9; k++) begin
            typeKey(4'(k), 64, 64);
        end
        checkOutput("nine_keys_entry_data", entry_data, 32'h23456789);

        // 4: bouncing 0xA never survives two frames
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'h1 << 10, 16);
            applyStimulus(16'h0, 16);
        end
        applyStimulus(16'h0, 64);
        checkOutput("bounce_entry_data", entry_data, exp_entry);

        // 5: 0x3 held, 0xC added (MULTI) and removed, then all released
        expectKey(4'h3, 1'b0);
        applyStimulus(16'h1 << 3, 64);
        applyStimulus((16'h1 << 3) | (16'h1 << 12), 32);
        applyStimulus(16'h1 << 3, 32);
        applyStimulus(16'h0, 64);
        checkOutput("multi_key_code", {28'h0, key_code}, 32'h3);
        checkOutput("multi_entry_data", entry_data, exp_entry);

        // 6: build 0x1234, then clear on the accept edge of key 0x5
        doReset();
        for (int k = 1; k <= 4; k++) begin
            typeKey(4'(k), 64, 64);
        end
        checkOutput("pre_clear_entry_data", entry_data, 32'h00001234);
        expectKey(4'h5, 1'b1);
        applyStimulus(16'h1 << 5, 31);
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        waitCycles(32);
        applyStimulus(16'h0, 64);
        checkOutput("clear_entry_data", entry_data, 32'h0);
        checkOutput("clear_key_code", {28'h0, key_code}, 32'h5);

        // reset in the middle of debouncing 0x7: no event for it
        applyStimulus(16'h1 << 7, 20);
        pressed = 16'h0;
        doReset();
        applyStimulus(16'h0, 64);
        checkOutput("post_reset_key_code", {28'h0, key_code}, 32'h0);
        checkOutput("post_reset_entry_data", entry_data, 32'h0);

        // 0x7 debounced again from scratch is accepted
        typeKey(4'h7, 64, 64);
        checkOutput("redebounce_entry_data", entry_data, 32'h00000007);

        checkOutput("scoreboard_drained", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_hex_entry.md
Name: keypad_hex_entry

Overview:
- Input-side companion to the 8-digit seven-segment display path. Scans a 4x4 hex matrix keypad by strobing active-low rows and sampling active-low columns.
- Debounces each key press and emits a one-cycle key event.
- Shifts each accepted hex digit into a 32-bit entry register. That register feeds the display data bus and CPU-facing logic, so typed digits appear right-justified on the display.

Parameters:
SCAN_DIV, 100000, clk cycles each row stays strobed (>=2)
DEBOUNCE, 4, consecutive identical frame results required to accept a press or release (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
row  output  4  row strobes, active-low, exactly one bit low at a time
col  input  4  column sense, active-low (external pull-ups)
clear  input  1  synchronous clear of entry_data
key_code  output  4  hex code of last accepted key
key_valid  output  1  one-cycle pulse on accepted press
entry_data  output  32  accumulated hex digits, newest in [3:0]

Behaviour:
- Reset (rst_n=0 at a clk edge), regardless of any scan or debounce in progress:
  - row=4'b1110, key_code=0, key_valid=0, entry_data=0.
  - Divider, row index, debounce counter and frame accumulator cleared; FSM=IDLE.
- Scan timing:
  - The divider counts 0..SCAN_DIV-1.
  - col is sampled on the cycle the divider equals SCAN_DIV-1. On that same edge, row rotates 1110->1101->1011->0111->1110.
  - One frame = 4*SCAN_DIV cycles. The frame result is evaluated when the sample for row index 3 is taken.
- Key mapping:
  - Row index r (low bit position of row) and column index c (low bit position of col) give code = 4*r + c, range 0x0..0xF.
- Frame result (one of three):
  - NONE: no column low in any row.
  - KEY(k): exactly one row/col intersection low.
  - MULTI: more than one intersection low. MULTI frames are ignored: they change neither state nor counter.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: on KEY(k), latch candidate=k, counter=1, go to PRESS_DB. If DEBOUNCE=1, accept immediately instead.
  - PRESS_DB:
    - KEY(candidate): counter++; when counter reaches DEBOUNCE, accept and go to HELD.
    - KEY(other): restart with new candidate, counter=1.
    - NONE: return to IDLE.
  - Accept (same edge as the final qualifying frame):
    - key_code<=candidate, key_valid=1 for exactly one cycle.
    - entry_data<={entry_data[27:0],candidate}.
  - HELD: any NONE goes to RELEASE_DB with counter=1; KEY frames stay. There is no auto-repeat, and a different key while held generates no event.
  - RELEASE_DB:
    - NONE: counter++; at DEBOUNCE go to IDLE.
    - Any KEY: return to HELD.
- entry_data wraps by shifting: the ninth digit discards the oldest digit in [31:28].
- clear=1:
  - entry_data<=0. If an accept occurs on the same edge, the result is 0 (clear wins) while key_code still updates and key_valid still pulses.
  - clear does not disturb scanning or the FSM.
- key_code holds its value between events.
- All outputs are registered. key_valid is asserted on the edge after the deciding sample.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE=2.
1. Reset then idle 64 cycles with col=4'hF -> row cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; entry_data=0.
2. Hold key at row index 1, col index 2 (col[2] low only while row[1]=0) for 5 frames, then release -> exactly one key_valid pulse, key_code=4'h6, entry_data=32'h00000006; pulse arrives at the end of the 2nd full pressed frame.
3. Enter keys 1,2,...,9 sequentially, each held 4 frames with 4 released frames between -> nine pulses; final entry_data=32'h23456789.
4. Bounce: key 0xA pressed for 1 frame, released 1 frame, repeated 3 times, then released -> no key_valid; entry_data unchanged.
5. Hold 0x3, then additionally press 0xC (MULTI), release 0xC, keep 0x3, release all -> a single pulse with key_code=4'h3.
6. Assert clear on the accept cycle of key 0x5 with entry_data=32'h1234 -> entry_data=0, key_code=4'h5, key_valid pulses. Then assert rst_n=0 mid-PRESS_DB of key 0x7 -> all outputs return to reset values and no pulse is emitted for 0x7 unless it is re-debounced.
